mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per requester; bit i is held high while requester i wants the channel.
REQ-005 D  input  4  data inputs; bit i belongs to requester i.
REQ-006 gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-007 S  output  2  registered select, equal to the index of the current owner; 0 when idle.
REQ-008 out  output  1  muxed data: D[S] while gnt is nonzero, else 0 (combinational from registered S/gnt and D).
REQ-009 busy  output  1  registered; high exactly when gnt is nonzero.
REQ-010 preempt  output  1  registered one-cycle pulse on timeout release.

Function
REQ-011 FSM has two states: IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-012 IDLE with req=0: remain in IDLE with all outputs at 0.
REQ-013 IDLE with req nonzero: next edge enters GRANT; owner = first set req bit searching last+1, last+2, last+3, last (mod 4), where last is the previous owner; req-to-gnt latency is 1 cycle.
REQ-014 On entering GRANT: last <= owner, S <= owner, gnt <= one-hot(owner), hold counter <= 0.
REQ-015 GRANT with req[owner] high and no timeout: hold gnt/S unchanged and increment the hold counter (8 bits, no wrap within the legal range).
REQ-016 GRANT with req[owner] low at an edge: return to IDLE with gnt=0 for at least one cycle; no regrant on the same edge.
REQ-017 Requests from non-owners never change gnt or S while in GRANT.
REQ-018 Changes on req bits other than the owner's take effect only at arbitration in IDLE; a request dropped before arbitration is not granted.
REQ-019 If the owner's request drops on the same edge as a timeout, treat it as a normal release (preempt stays 0).
REQ-020 S and gnt change only together, on the same edge; S never changes while gnt is nonzero.

Reset
REQ-021 rst_n low: immediately force IDLE, gnt=0, S=0, busy=0, preempt=0, hold counter=0, last=3 (requester 0 has highest priority on first arbitration).
REQ-022 Reset asserted mid-grant aborts the grant without waiting for a clock edge; out goes to 0 immediately.
REQ-023 Reset deassertion is sampled on clk; the first arbitration occurs at the first rising edge with rst_n high and req nonzero.

Configuration
REQ-024 Macro MUX4_ARB_TIMEOUT_EN compiles in hold-limit pre-emption.
REQ-025 With MUX4_ARB_TIMEOUT_EN defined: in GRANT, when the hold counter equals MAX_HOLD-1 and req[owner] is still high, the next edge returns to IDLE and pulses preempt for 1 cycle; last keeps the pre-empted owner, so other requesters win the next arbitration.
REQ-026 Without MUX4_ARB_TIMEOUT_EN: no hold counter exists, preempt is tied to 0, MAX_HOLD is ignored, and a grant persists until req[owner] drops.

Verification
REQ-027 Reset then req=4'b0001 at cycle 0 -> gnt=0001, S=0, busy=1 at cycle 1; D=4'b0001 -> out=1.
REQ-028 req=4'b1111 held, each owner drops its req for 1 cycle after 3 granted cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-029 Timeout enabled, MAX_HOLD=4, req=4'b0011 held -> gnt=0001 for 4 cycles, preempt=1 with gnt=0 for 1 cycle, then gnt=0010 for 4 cycles.
REQ-030 Timeout disabled, req=4'b0011 held for 20 cycles -> gnt=0001 for all 19 granted cycles, preempt never 1.
REQ-031 rst_n pulled low between edges during gnt=0100 -> gnt, S, busy, out all 0 before the next edge; after release with req=4'b0100 -> gnt=0100 one cycle later.
REQ-032 Owner 2 drops req on the same edge the timeout fires (MAX_HOLD=2) -> IDLE, preempt stays 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant, select and a muxed data bit.
// Define MUX4_ARB_TIMEOUT_EN to compile in hold-limit pre-emption after MAX_HOLD granted cycles.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] D,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       out,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_preempt, w_preempt_nxt;
  logic [1:0] w_winner;
  logic       w_timeout;

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  assign w_timeout = (r_hold == 8'(MAX_HOLD - 1));

  // Idle forces the count to zero, so every new grant starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_hold <= 8'd0;
    else if (r_state == ST_IDLE) r_hold <= 8'd0;
    else if (req[r_sel])        r_hold <= r_hold + 8'd1;
  end
`else
  logic w_unused_max_hold;

  assign w_timeout         = 1'b0;
  assign w_unused_max_hold = ^8'(MAX_HOLD);
`endif

  // Search last+1, last+2, last+3, last; descending loop lets the nearest candidate win.
  always_comb begin
    w_winner = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(r_last + 2'(k))]) w_winner = 2'(r_last + 2'(k));
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_sel_nxt     = r_sel;
    w_gnt_nxt     = r_gnt;
    w_busy_nxt    = r_busy;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_last_nxt  = w_winner;
          w_sel_nxt   = w_winner;
          w_gnt_nxt   = 4'b0001 << w_winner;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        // A dropped request beats a coincident timeout: that is a normal release.
        if (!req[r_sel] || w_timeout) begin
          w_state_nxt   = ST_IDLE;
          w_sel_nxt     = 2'd0;
          w_gnt_nxt     = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_preempt_nxt = req[r_sel];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = 2'd0;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 2'd3;
      r_sel     <= 2'd0;
      r_gnt     <= 4'b0000;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign S       = r_sel;
  assign busy    = r_busy;
  assign preempt = r_preempt;
  assign out     = (r_gnt != 4'b0000) ? D[r_sel] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a behavioural round-robin model.
// Define MUX4_ARB_TIMEOUT_EN for both files to exercise the pre-emption scenarios.
module tb_mux4_rr_arbiter;

  localparam int unsigned TB_MAX_HOLD = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] D;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       out;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: owner is -1 when idle.
  int m_owner;
  int m_last;
  int m_held;
  bit m_pre;

  logic [3:0] prev_gnt;
  int         grant_order[$];

  mux4_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .D       (D),
    .gnt     (gnt),
    .S       (S),
    .out     (out),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_pre   = 1'b0;
  endfunction

  // One rising edge of the arbiter, from the rules: rotate priority, hold, release, pre-empt.
  function automatic void model_edge(input logic [3:0] r);
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (r[c] && m_owner < 0) begin
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TMO_EN && m_held >= int'(TB_MAX_HOLD)) begin
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic check_all(input string ctx);
    logic [3:0] e_gnt;
    logic [1:0] e_s;
    logic       e_out;
    e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e_s   = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e_out = (m_owner < 0) ? 1'b0 : D[m_owner];
    check({ctx, ".gnt"},     8'(gnt),     8'(e_gnt));
    check({ctx, ".S"},       8'(S),       8'(e_s));
    check({ctx, ".busy"},    8'(busy),    8'(m_owner >= 0));
    check({ctx, ".out"},     8'(out),     8'(e_out));
    check({ctx, ".preempt"}, 8'(preempt), 8'(m_pre));
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Drive inputs away from the edge, clock once, sample on the falling edge.
  task automatic step(input string ctx, input logic [3:0] r, input logic [3:0] d);
    req = r;
    D   = d;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_all(ctx);
    if (gnt != 4'b0000 && prev_gnt == 4'b0000) grant_order.push_back(onehot_idx(gnt));
    prev_gnt = gnt;
  endtask

  // Assert reset between edges, confirm outputs clear before any clock, release on a falling edge.
  task automatic do_reset(input string ctx);
    rst_n = 1'b0;
    #1;
    check({ctx, ".rst_gnt"},  8'(gnt),     8'h00);
    check({ctx, ".rst_S"},    8'(S),       8'h00);
    check({ctx, ".rst_busy"}, 8'(busy),    8'h00);
    check({ctx, ".rst_out"},  8'(out),     8'h00);
    check({ctx, ".rst_pre"},  8'(preempt), 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    prev_gnt = 4'b0000;
  endtask

  initial begin
    int cnt_g0, cnt_g1, cnt_pre;
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0000;
    D     = 4'b0000;
    prev_gnt = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("init");
    step("idle0", 4'b0000, 4'b1111);

    // First grant: requester 0, one-cycle latency, data routed.
    step("first", 4'b0001, 4'b0001);
    check("first_gnt", 8'(gnt), 8'h01);
    check("first_out", 8'(out), 8'h01);

    // All requesting, each owner releases for one cycle after three granted cycles.
    do_reset("rr");
    grant_order.delete();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) step("rr", 4'b1111, 4'($urandom_range(0, 15)));
      step("rr_drop", 4'b1111 & ~4'(1 << (g % 4)), 4'($urandom_range(0, 15)));
    end
    check("rr_ngrants", 8'(grant_order.size()), 8'd5);
    for (int i = 0; i < grant_order.size() && i < 5; i++)
      check($sformatf("rr_order%0d", i), 8'(grant_order[i]), 8'(i % 4));

`ifdef MUX4_ARB_TIMEOUT_EN
    // Pre-emption: two persistent requesters alternate every TB_MAX_HOLD cycles.
    do_reset("tmo");
    cnt_g0 = 0; cnt_g1 = 0; cnt_pre = 0;
    for (int i = 0; i < 2 * int'(TB_MAX_HOLD) + 2; i++) begin
      step("tmo", 4'b0011, 4'b0010);
      if (gnt == 4'b0001) cnt_g0++;
      if (gnt == 4'b0010) cnt_g1++;
      if (preempt) begin
        cnt_pre++;
        check("tmo_pre_gnt", 8'(gnt), 8'h00);
      end
    end
    check("tmo_g0_cycles", 8'(cnt_g0), 8'(TB_MAX_HOLD));
    check("tmo_g1_cycles", 8'(cnt_g1), 8'(TB_MAX_HOLD));
    check("tmo_pulses",    8'(cnt_pre), 8'd2);

    // Owner 2 releases on the very edge the hold limit is reached: plain release.
    do_reset("tmo_rel");
    for (int i = 0; i < int'(TB_MAX_HOLD); i++) step("tmo_rel", 4'b0100, 4'b0100);
    step("tmo_rel_edge", 4'b0000, 4'b0100);
    check("tmo_rel_pre", 8'(preempt), 8'h00);
    check("tmo_rel_gnt", 8'(gnt), 8'h00);
`else
    // No pre-emption: grant persists for as long as the owner requests.
    do_reset("hold");
    cnt_g0 = 0; cnt_pre = 0;
    for (int i = 0; i < 19; i++) begin
      step("hold", 4'b0011, 4'b0001);
      if (gnt == 4'b0001) cnt_g0++;
      if (preempt) cnt_pre++;
    end
    check("hold_g0_cycles", 8'(cnt_g0), 8'd19);
    check("hold_pulses", 8'(cnt_pre), 8'd0);
`endif

    // Reset mid-grant clears everything between edges; grant returns one cycle after release.
    do_reset("mid");
    step("mid", 4'b0100, 4'b0100);
    check("mid_gnt", 8'(gnt), 8'h04);
    do_reset("mid_abort");
    step("mid_regrant", 4'b0100, 4'b0100);
    check("mid_regrant_gnt", 8'(gnt), 8'h04);

    // Random traffic with sticky requests and occasional asynchronous resets.
    do_reset("rnd");
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step("rnd", r, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
